// File: rtl/depth_tester.sv
// depth_tester: per-pixel z-buffer depth test with in-flight write forwarding and frame clear
module depth_tester #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int DEPTH_BITS = 16,
  parameter int ADDR_BITS  = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  clear_in,
  output logic                  clearing_out,
  input  logic                  valid_in,
  input  logic [15:0]           triangle_id_in,
  input  logic [2:0][16:0]      fragment_in,
  input  logic [2:0][31:0]      normal_in,
  input  logic [11:0]           material_in,
  output logic                  valid_out,
  output logic [15:0]           triangle_id_out,
  output logic [ADDR_BITS-1:0]  addr_out,
  output logic [DEPTH_BITS-1:0] depth_out,
  output logic [2:0][31:0]      normal_out,
  output logic [11:0]           material_out,
  output logic                  overrun_out
);
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int IW = $clog2(PIXELS);
  typedef enum logic [1:0] {READY, CLEAR_WAIT, CLEARING} state_t;
  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [DEPTH_BITS-1:0] depth;
    logic [15:0]           tri_id;
    logic [2:0][31:0]      normal;
    logic [11:0]           material;
  } frag_t;
  state_t state;
  logic [ADDR_BITS-1:0] cnt;
  frag_t s [4];
  frag_t f_in;
  logic [3:0] v;
  logic [DEPTH_BITS-1:0] mem [PIXELS];
  logic [DEPTH_BITS-1:0] rd1, rd2, stored;
  logic [8:0] xi, yi;
  logic on_screen, pass, we;
  always_comb begin
    xi = fragment_in[0][16:8];
    yi = fragment_in[1][16:8];
    on_screen = int'(xi) < WIDTH && int'(yi) < HEIGHT;
    f_in.addr = ADDR_BITS'(int'(yi) * WIDTH + int'(xi));
    f_in.depth = fragment_in[2][16 -: DEPTH_BITS];
    f_in.tri_id = triangle_id_in;
    f_in.normal = normal_in;
    f_in.material = material_in;
    // the two most recent passes have not reached the value read from memory yet
    stored = v[3] && s[3].addr == s[2].addr ? s[3].depth
           : valid_out && addr_out == s[2].addr ? depth_out : rd2;
    pass = v[2] && s[2].depth < stored;
    we = state == CLEARING || pass;
  end
  always_ff @(posedge clk_in) begin
    if (we) mem[state == CLEARING ? cnt[IW-1:0] : s[2].addr[IW-1:0]] <= state == CLEARING ? '1 : s[2].depth;
    rd1 <= mem[s[0].addr[IW-1:0]];
    rd2 <= rd1;
    s[0] <= f_in;
    s[1] <= s[0];
    s[2] <= s[1];
    s[3] <= s[2];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v <= '0;
      valid_out <= 1'b0;
      triangle_id_out <= '0;
      addr_out <= '0;
      depth_out <= '0;
      normal_out <= '0;
      material_out <= '0;
      overrun_out <= 1'b0;
      clearing_out <= 1'b0;
      state <= READY;
      cnt <= '0;
    end else begin
      v <= {pass, v[1:0], valid_in && on_screen && state != CLEARING};
      valid_out <= v[3];
      if (v[3]) begin
        triangle_id_out <= s[3].tri_id;
        addr_out <= s[3].addr;
        depth_out <= s[3].depth;
        normal_out <= s[3].normal;
        material_out <= s[3].material;
      end
      if (state == CLEARING && valid_in) overrun_out <= 1'b1;
      case (state)
        READY: if (clear_in) begin
          state <= CLEAR_WAIT;
          clearing_out <= 1'b1;
        end
        CLEAR_WAIT: if (v == '0 && !valid_out && !valid_in) begin
          state <= CLEARING;
          cnt <= '0;
        end
        CLEARING: begin
          if (cnt == ADDR_BITS'(PIXELS - 1)) begin
            state <= READY;
            clearing_out <= 1'b0;
          end
          cnt <= cnt + 1'b1;
        end
        default: state <= READY;
      endcase
    end
  end
endmodule

// File: tb/tb_depth_tester.sv
// tb_depth_tester: randomized and directed checks of depth_tester against a sequential z-buffer model
module tb_depth_tester;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = 2048;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, vin = 1'b0;
  logic clearing_out, valid_out, overrun_out;
  logic [15:0] tri_in = '0, tri_out;
  logic [2:0][16:0] frag_in = '0;
  logic [2:0][31:0] nrm_in = '0, nrm_out;
  logic [11:0] mat_in = '0, mat_out;
  logic [16:0] addr_out;
  logic [15:0] depth_out;
  int checks = 0, errors = 0, cyc = 0;
  bit exp_ovr = 1'b0;
  bit exp_v [N];
  logic [16:0] exp_a [N];
  logic [15:0] exp_d [N], exp_t [N];
  logic [2:0][31:0] exp_n [N];
  logic [11:0] exp_m [N];
  int zb [W*H];
  always #5 clk = ~clk;
  depth_tester #(.WIDTH(W), .HEIGHT(H), .DEPTH_BITS(16), .ADDR_BITS(17)) dut (
    .clk_in(clk), .rst_in(rst), .clear_in(clr), .clearing_out(clearing_out),
    .valid_in(vin), .triangle_id_in(tri_in), .fragment_in(frag_in),
    .normal_in(nrm_in), .material_in(mat_in), .valid_out(valid_out),
    .triangle_id_out(tri_out), .addr_out(addr_out), .depth_out(depth_out),
    .normal_out(nrm_out), .material_out(mat_out), .overrun_out(overrun_out)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("valid_out", valid_out, exp_v[cyc]);
    chk("overrun_out", overrun_out, exp_ovr);
    if (exp_v[cyc]) begin
      chk("addr_out", addr_out, exp_a[cyc]);
      chk("depth_out", depth_out, exp_d[cyc]);
      chk("triangle_id_out", tri_out, exp_t[cyc]);
      chk("normal_out", nrm_out, exp_n[cyc]);
      chk("material_out", mat_out, exp_m[cyc]);
    end
  endtask
  // sequential reference: a fragment sampled on the next edge appears 4 edges after it
  task automatic frag(input logic [16:0] x, input logic [16:0] y, input logic [16:0] z, input bit clearing);
    int xi, yi, a, d, e;
    tri_in = 16'($urandom);
    nrm_in = {$urandom, $urandom, $urandom};
    mat_in = 12'($urandom);
    frag_in = {z, y, x};
    vin = 1'b1;
    xi = int'(x) / 256;
    yi = int'(y) / 256;
    d = int'(z) / 2;
    if (clearing) exp_ovr = 1'b1;
    else if (xi < W && yi < H) begin
      a = yi * W + xi;
      if (d < zb[a]) begin
        zb[a] = d;
        e = cyc + 5;
        exp_v[e] = 1'b1;
        exp_a[e] = 17'(a);
        exp_d[e] = 16'(d);
        exp_t[e] = tri_in;
        exp_n[e] = nrm_in;
        exp_m[e] = mat_in;
      end
    end
    tick();
    vin = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_clear();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clearing_rise", clearing_out, 1'b1);
    n = 1;
    for (int i = 0; i < 100 && clearing_out; i++) begin
      tick();
      if (clearing_out) n++;
    end
    chk("clear_length", n, 33);
    for (int i = 0; i < W*H; i++) zb[i] = 32'hFFFF;
  endtask
  task automatic rand_frag();
    logic [16:0] x, y, z;
    x = {9'($urandom_range(0, 9)), 8'($urandom)};
    y = {9'($urandom_range(0, 4)), 8'($urandom)};
    z = 17'($urandom);
    frag(x, y, z, 1'b0);
  endtask
  initial begin
    tick();
    tick();
    chk("reset_clearing", clearing_out, 1'b0);
    chk("reset_addr", addr_out, 17'd0);
    chk("reset_depth", depth_out, 16'd0);
    chk("reset_tri", tri_out, 16'd0);
    rst = 1'b0;
    tick();
    do_clear();
    frag(17'h0280, 17'h0180, 17'h08000, 1'b0);
    idle(6);
    frag(17'h0300, 17'h0200, 17'h08000, 1'b0);
    frag(17'h0300, 17'h0200, 17'h06000, 1'b0);
    frag(17'h0300, 17'h0200, 17'h07000, 1'b0);
    idle(6);
    frag(17'h0500, 17'h0100, 17'h04000, 1'b0);
    idle(2);
    frag(17'h0500, 17'h0100, 17'h04000, 1'b0);
    idle(6);
    frag(17'h0880, 17'h0100, 17'h00010, 1'b0);
    frag(17'h0100, 17'h0400, 17'h00010, 1'b0);
    frag(17'h0000, 17'h0200, 17'h1FFFC, 1'b0);
    frag(17'h0100, 17'h0000, 17'h1FFFC, 1'b0);
    idle(6);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rand_frag();
      else tick();
    end
    idle(6);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    frag(17'h0100, 17'h0100, 17'h00100, 1'b1);
    idle(8);
    chk("clearing_mid", clearing_out, 1'b1);
    rst = 1'b1;
    exp_ovr = 1'b0;
    tick();
    chk("abort_clearing", clearing_out, 1'b0);
    rst = 1'b0;
    tick();
    do_clear();
    for (int i = 0; i < 100; i++) rand_frag();
    idle(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
